// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode type and opcode encodings shared by alu_core and alu_5op.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'd0;
  localparam alu_op_t OP_SUB = 3'd1;
  localparam alu_op_t OP_MUL = 3'd2;
  localparam alu_op_t OP_AND = 3'd3;
  localparam alu_op_t OP_OR  = 3'd4;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// alu_core : combinational five-operation decode on zero-extended operands.
//            Opcode OP_MUL is only implemented when ALU_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  alu_op_t                control,
  input  logic [WIDTH-1:0]       in_data1,
  input  logic [WIDTH-1:0]       in_data2,
  output logic [2*WIDTH-1:0]     out_data
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, in_data1};
  assign b_ext = {{WIDTH{1'b0}}, in_data2};

  // Double-width arithmetic keeps the ADD carry and full MUL product;
  // SUB wraps modulo 2^(2*WIDTH).
  always_comb begin
    out_data = '0;
    case (control)
      OP_ADD:  out_data = a_ext + b_ext;
      OP_SUB:  out_data = a_ext - b_ext;
`ifdef ALU_MUL_EN
      OP_MUL:  out_data = a_ext * b_ext;
`endif
      OP_AND:  out_data = a_ext & b_ext;
      OP_OR:   out_data = a_ext | b_ext;
      default: out_data = '0;
    endcase
  end

endmodule : alu_core

`default_nettype wire

// File: rtl/alu_5op.sv
// ============================================================================
// alu_5op : registered five-operation ALU, one-cycle latency, no backpressure.
//           Define ALU_MUL_EN to enable the multiply opcode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_5op
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [2:0]             control,
  input  logic [WIDTH-1:0]       in_data1,
  input  logic [WIDTH-1:0]       in_data2,
  output logic                   out_valid,
  output logic [2*WIDTH-1:0]     out_data
);

  logic [2*WIDTH-1:0] core_res;
  logic [2*WIDTH-1:0] data_d;
  logic [2*WIDTH-1:0] data_q;
  logic               valid_q;

  alu_core #(
    .WIDTH    (WIDTH)
  ) u_core (
    .control  (alu_op_t'(control)),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .out_data (core_res)
  );

  // Result only advances on an accepted transaction; otherwise it holds.
  assign data_d = in_valid ? core_res : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= in_valid;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule : alu_5op

`default_nettype wire

// File: tb/tb_alu_5op.sv
// ============================================================================
// tb_alu_5op : self-checking bench for alu_5op (WIDTH=4), directed table,
//              exhaustive sweep, random traffic, reset and hold sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_5op;

  localparam int W = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [2:0]     control;
  logic [W-1:0]   in_data1;
  logic [W-1:0]   in_data2;
  logic           out_valid;
  logic [2*W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  alu_5op #(
    .WIDTH     (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .control   (control),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  // Reference: plain integer arithmetic reduced modulo 2^(2W).
  function automatic logic [2*W-1:0] ref_alu(int op, int a, int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = MUL_EN ? a * b : 0;
      3:       r = a & b;
      4:       r = a | b;
      default: r = 0;
    endcase
    r = r & ((1 << (2 * W)) - 1);
    return r[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    control  = op;
    in_data1 = a;
    in_data2 = b;
    @(posedge clk);
    #1;
  endtask

  logic [2*W-1:0] exp_data;
  logic           exp_valid;
  logic [2*W-1:0] held;

  initial begin
    tbl[0] = '{3'd0, 4'd15, 4'd15, 8'h1E};
    tbl[1] = '{3'd1, 4'd3,  4'd5,  8'hFE};
    tbl[2] = '{3'd2, 4'd15, 4'd15, (MUL_EN ? 8'hE1 : 8'h00)};
    tbl[3] = '{3'd3, 4'hC,  4'hA,  8'h08};
    tbl[4] = '{3'd4, 4'hC,  4'hA,  8'h0E};
    tbl[5] = '{3'd5, 4'hC,  4'hA,  8'h00};
    tbl[6] = '{3'd6, 4'hF,  4'hF,  8'h00};
    tbl[7] = '{3'd7, 4'h7,  4'h9,  8'h00};
    tbl[8] = '{3'd1, 4'd0,  4'd1,  8'hFF};
    tbl[9] = '{3'd0, 4'd9,  4'd8,  8'h11};

    rst_n = 1'b0; in_valid = 1'b0; control = '0; in_data1 = '0; in_data2 = '0;
    #3;
    chk("reset_data", 32'(out_data), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'h1);
    end

    // Hold: one-cycle valid pulse, then data frozen while inputs wiggle
    held = tbl[9].exp;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 3'(k), 4'(k * 3 + 1), 4'(15 - k));
      chk("hold_data", 32'(out_data), 32'(held));
      chk("hold_valid", 32'(out_valid), 32'h0);
    end

    // Exhaustive sweep, back-to-back
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, 3'(op), 4'(a), 4'(b));
          chk($sformatf("exh op%0d a%0d b%0d", op, a, b), 32'(out_data), 32'(ref_alu(op, a, b)));
          chk("exh_valid", 32'(out_valid), 32'h1);
        end

    // Random traffic with sparse in_valid
    exp_data = out_data === ref_alu(7, 15, 15) ? 8'h00 : 8'h00;
    exp_data = 8'h00;
    for (int k = 0; k < 300; k++) begin
      logic       v;
      logic [2:0] op;
      logic [3:0] a, b;
      v  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      if (v) exp_data = ref_alu(int'(op), int'(a), int'(b));
      exp_valid = v;
      drive(v, op, a, b);
      chk("rnd_data", 32'(out_data), 32'(exp_data));
      chk("rnd_valid", 32'(out_valid), 32'(exp_valid));
    end

    // Reset mid-stream: nonzero result, then a pending transaction is killed
    drive(1'b1, 3'd0, 4'd7, 4'd6);
    chk("prerst_data", 32'(out_data), 32'h0D);
    @(negedge clk);
    in_valid = 1'b1; control = 3'd4; in_data1 = 4'h5; in_data2 = 4'hA;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", 32'(out_data), 32'h0);
    chk("rst_async_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_data", 32'(out_data), 32'h0);
    chk("rst_hold_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle_valid", 32'(out_valid), 32'h0);
    chk("post_rst_idle_data", 32'(out_data), 32'h0);
    drive(1'b1, 3'd1, 4'd2, 4'd9);
    chk("post_rst_data", 32'(out_data), 32'hF9);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("post_rst_pulse", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_5op

`default_nettype wire
